// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, single-outstanding imem request FSM and instruction register for decode.
// Define FETCH_PERF_CNT_EN to add fetch_count/stall_count performance counters.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic [1:0] {REQ, WAIT, VALID} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic [31:0] seq, next_pc;
  logic        accept, capture;
  always_comb begin
    accept     = state_q == VALID && instr_ready;
    capture    = state_q == WAIT && imem_rsp_valid;
    seq        = instr_pc_q + 32'd4;
    next_pc    = jump ? {seq[31:28], jump_target, 2'b00}
               : branch_taken ? seq + {{14{branch_offset[15]}}, branch_offset, 2'b00}
               : instr_pc_q + 32'(PC_STEP);
    state_d    = (state_q == REQ && imem_req_ready) ? WAIT
               : capture ? VALID
               : accept ? REQ
               : state_q;
    pc_d       = accept ? next_pc : pc_q;
    instr_d    = capture ? imem_rsp_data : instr_q;
    instr_pc_d = capture ? pc_q : instr_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end
  // Request is suppressed while rst is high so nothing is issued in the reset cycle.
  assign imem_req_valid = state_q == REQ && !rst;
  assign imem_addr      = pc_q;
  assign instr_valid    = state_q == VALID;
  assign instruction    = instr_q;
  assign instr_pc       = instr_pc_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;
  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, accept};
    stall_count_d = stall_count_q + {31'd0, state_q == VALID && !instr_ready};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;
  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instruction, instr_pc;
  logic        branch_taken = 0;
  logic [15:0] branch_offset = 0;
  logic        jump = 0;
  logic [25:0] jump_target = 0;
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif
  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Starting in REQ: issue at address a, zero-wait response d, end in VALID.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    imem_req_ready = 1;
    chk("req_valid", {31'd0, imem_req_valid}, 1);
    chk("req_addr", imem_addr, a);
    chk("no_instr_in_req", {31'd0, instr_valid}, 0);
    step();
    imem_req_ready = 0;
    chk("wait_no_req", {31'd0, imem_req_valid}, 0);
    chk("wait_no_instr", {31'd0, instr_valid}, 0);
    imem_rsp_valid = 1;
    imem_rsp_data = d;
    step();
    imem_rsp_valid = 0;
    chk("instr_valid", {31'd0, instr_valid}, 1);
    chk("instruction", instruction, d);
    chk("instr_pc", instr_pc, a);
  endtask
  task automatic accept(input logic j, input logic [25:0] jt, input logic b, input logic [15:0] bo);
    jump = j; jump_target = jt; branch_taken = b; branch_offset = bo;
    instr_ready = 1;
    step();
    instr_ready = 0; jump = 0; jump_target = 0; branch_taken = 0; branch_offset = 0;
    accepted++;
    chk("back_to_req", {31'd0, instr_valid}, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_pc", imem_addr, 32'h0);
    rst = 0;
    #1;
    // Sequential stream
    fetch(32'h0, 32'hA000_0001); accept(0, 0, 0, 0);
    fetch(32'h4, 32'hA000_0002); accept(0, 0, 0, 0);
    fetch(32'h8, 32'hA000_0003); accept(0, 0, 0, 0);
    fetch(32'hC, 32'hA000_0004); accept(0, 0, 0, 0);
    // Branches: 0x14 - 16 = 0x4; 0x8 + 8 = 0x10; 0x14 + 12 = 0x20
    fetch(32'h10, 32'hB000_0001); accept(0, 0, 1, 16'hFFFC);
    fetch(32'h4, 32'hB000_0002); accept(0, 0, 1, 16'h0002);
    fetch(32'h10, 32'hB000_0003); accept(0, 0, 1, 16'h0003);
    // 0x24 - 0x34 wraps below zero to 0xFFFF_FFF0
    fetch(32'h20, 32'hB000_0004); accept(0, 0, 1, 16'hFFF3);
    // Jump keeps upper nibble F: {F, 0000002, 00}
    fetch(32'hFFFF_FFF0, 32'hC000_0001); accept(1, 26'h0000002, 0, 0);
    // Jump beats branch
    fetch(32'hF000_0008, 32'hC000_0002); accept(1, 26'h0000040, 1, 16'h0005);
    fetch(32'hF000_0100, 32'hC000_0003); accept(1, 26'h3FF_FFFF, 0, 0);
    // Stall 5 cycles in VALID with noisy response and branch inputs
    fetch(32'hFFFF_FFFC, 32'hD000_0001);
    branch_taken = 1; branch_offset = 16'h0100; jump = 1; jump_target = 26'h1234;
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = i[0];
      imem_rsp_data = 32'hDEAD_0000 + i;
      step();
      chk("stall_instr", instruction, 32'hD000_0001);
      chk("stall_ipc", instr_pc, 32'hFFFF_FFFC);
      chk("stall_no_req", {31'd0, imem_req_valid}, 0);
      chk("stall_valid", {31'd0, instr_valid}, 1);
    end
    imem_rsp_valid = 0;
`ifdef FETCH_PERF_CNT_EN
    chk("stall_count", stall_count, 5);
    chk("fetch_count", fetch_count, accepted);
`endif
    // Sequential wrap to 0
    accept(0, 0, 0, 0);
    // Memory not ready for 4 cycles, stray responses ignored
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = i[0];
      imem_rsp_data = 32'hBAD0_0000 + i;
      chk("hold_req", {31'd0, imem_req_valid}, 1);
      chk("hold_addr", imem_addr, 32'h0);
      step();
    end
    imem_rsp_valid = 0;
    chk("hold_addr_end", imem_addr, 32'h0);
    chk("hold_no_instr", {31'd0, instr_valid}, 0);
    imem_req_ready = 1;
    step();
    imem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("slow_no_req", {31'd0, imem_req_valid}, 0);
      chk("slow_no_instr", {31'd0, instr_valid}, 0);
      step();
    end
    imem_rsp_valid = 1;
    imem_rsp_data = 32'hE000_0001;
    step();
    imem_rsp_valid = 0;
    imem_rsp_data = 32'hE000_0002;
    chk("slow_valid", {31'd0, instr_valid}, 1);
    chk("slow_instr", instruction, 32'hE000_0001);
    chk("slow_ipc", instr_pc, 32'h0);
    step();
    chk("slow_single", instruction, 32'hE000_0001);
    accept(0, 0, 0, 0);
    // Reset during WAIT
    imem_req_ready = 1;
    chk("pre_rst_addr", imem_addr, 32'h4);
    step();
    imem_req_ready = 0;
    rst = 1;
    step();
    chk("rstw_req_valid", {31'd0, imem_req_valid}, 0);
    chk("rstw_instr_valid", {31'd0, instr_valid}, 0);
    chk("rstw_pc", imem_addr, 32'h0);
    rst = 0;
    #1;
    chk("rstw_restart", {31'd0, imem_req_valid}, 1);
    fetch(32'h0, 32'hF000_0001); accept(0, 0, 0, 0);
    // Reset during stalled VALID
    fetch(32'h4, 32'hF000_0002);
    rst = 1;
    step();
    chk("rstv_instr_valid", {31'd0, instr_valid}, 0);
    chk("rstv_instruction", instruction, 0);
    chk("rstv_instr_pc", instr_pc, 0);
    chk("rstv_pc", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_count", fetch_count, 0);
    chk("rst_stall_count", stall_count, 0);
`endif
    rst = 0;
    #1;
    fetch(32'h0, 32'hF000_0003); accept(0, 0, 0, 0);
    chk("restart_next", imem_addr, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
